ram_arbiter: RTL

//  Shares one 128-bit line-wide RAM controller port among three requesters:

---
 rtl/ram_arbiter_pkg.sv | 21 ++
 rtl/ram_arb_pick.sv | 37 +++
 rtl/ram_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM line-port arbiter.
//  - owner_t : which requester currently holds the RAM controller port
//  - state_t : arbiter FSM states
//  - AW/DW defaults and starvation counter width
package ram_arbiter_pkg;
  localparam int AW_DEF = 25;
  localparam int DW_DEF = 128;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2,
    OWN_AUX  = 2'd3
  } owner_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant selection: fixed priority data > inst > aux, except
// that a starved aux (starve_cnt at STARVE_MAX) wins outright.
//  inst_stb/data_stb/aux_stb in  : live request lines
//  starve_cnt                in  : current aux starvation count
//  winner                    out : owner code of the winner (OWN_NONE if no request)
//  starve_nxt                out : count to load if this grant is taken
module ram_arb_pick
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             inst_stb,
  input  logic             data_stb,
  input  logic             aux_stb,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic [1:0]       winner,
  output logic [CNT_W-1:0] starve_nxt
);
  localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

  owner_t win;

  always_comb begin
    win = OWN_NONE;
    if (aux_stb && starve_cnt == SMAX) win = OWN_AUX;
    else if (data_stb)                 win = OWN_DATA;
    else if (inst_stb)                 win = OWN_INST;
    else if (aux_stb)                  win = OWN_AUX;

    // Count only grants aux lost while asking; anything else clears it.
    starve_nxt = '0;
    if (aux_stb && win != OWN_AUX)
      starve_nxt = (starve_cnt >= SMAX) ? SMAX : starve_cnt + 1'b1;
  end

  assign winner = win;
endmodule

// File: rtl/ram_arbiter.sv
// Shares one line-wide RAM controller port among inst cache (read-only),
// data cache (r/w) and an aux master (r/w). One whole line transaction at
// a time; owner latched in IDLE and held until mem_ack/mem_timeout.
//  clk, rst                     : clock, synchronous active-high reset
//  inst_*                       : inst read request / response
//  data_*, aux_*                : r/w request / response
//  mem_*                        : RAM controller port
// Read data is broadcast to all requesters; each qualifies with its own ack.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_stb,
  input  logic [AW-1:0] inst_addr,
  output logic [DW-1:0] inst_dout,
  output logic          inst_ack,
  output logic          inst_timeout,
  input  logic          data_stb,
  input  logic          data_we,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_din,
  output logic [DW-1:0] data_dout,
  output logic          data_ack,
  output logic          data_timeout,
  input  logic          aux_stb,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_din,
  output logic [DW-1:0] aux_dout,
  output logic          aux_ack,
  output logic          aux_timeout,
  output logic          mem_stb,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ack,
  input  logic          mem_timeout
);
  state_t           state, state_nxt;
  owner_t           owner, owner_nxt;
  logic [CNT_W-1:0] starve_cnt, cnt_nxt;
  logic [1:0]       pick_win;
  logic [CNT_W-1:0] pick_cnt;
  logic             busy, done_ok, done_to;

  ram_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .inst_stb   (inst_stb),
    .data_stb   (data_stb),
    .aux_stb    (aux_stb),
    .starve_cnt (starve_cnt),
    .winner     (pick_win),
    .starve_nxt (pick_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = starve_cnt;
    case (state)
      ST_IDLE: if (inst_stb || data_stb || aux_stb) begin
        state_nxt = ST_BUSY;
        owner_nxt = owner_t'(pick_win);
        cnt_nxt   = pick_cnt;
      end
      ST_BUSY: if (mem_ack || mem_timeout) begin
        state_nxt = ST_IDLE;
        owner_nxt = OWN_NONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Completion is only meaningful in BUSY; timeout dominates ack.
  assign busy    = (state == ST_BUSY);
  assign done_ok = busy && mem_ack && !mem_timeout;
  assign done_to = busy && mem_timeout;

  assign inst_ack     = done_ok && (owner == OWN_INST);
  assign data_ack     = done_ok && (owner == OWN_DATA);
  assign aux_ack      = done_ok && (owner == OWN_AUX);
  assign inst_timeout = done_to && (owner == OWN_INST);
  assign data_timeout = done_to && (owner == OWN_DATA);
  assign aux_timeout  = done_to && (owner == OWN_AUX);

  assign inst_dout = mem_dout;
  assign data_dout = mem_dout;
  assign aux_dout  = mem_dout;

  assign mem_stb = busy;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    case (owner)
      OWN_INST: mem_addr = inst_addr;
      OWN_DATA: begin mem_we = data_we; mem_addr = data_addr; mem_din = data_din; end
      OWN_AUX:  begin mem_we = aux_we;  mem_addr = aux_addr;  mem_din = aux_din;  end
      default: ;
    endcase
    if (!busy) mem_we = 1'b0;
  end
endmodule
